// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the client engines, the SRAM port arbiter and the dual-port SRAM macro.
// The arbiter takes the slave modport; the client/SRAM side takes the master modport.
interface sram_port_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 12,
   parameter int DW      = 128
);
   logic [NUM_REQ-1:0]    w_req;
   logic [NUM_REQ*AW-1:0] w_addr;
   logic [NUM_REQ*DW-1:0] w_data;
   logic [NUM_REQ-1:0]    w_gnt;
   logic [NUM_REQ-1:0]    r_req;
   logic [NUM_REQ*AW-1:0] r_addr;
   logic [NUM_REQ-1:0]    r_gnt;
   logic [NUM_REQ-1:0]    r_valid;
   logic [DW-1:0]         r_data;
   logic                  sram_ena;
   logic                  sram_wea;
   logic [AW-1:0]         sram_addra;
   logic [DW-1:0]         sram_dina;
   logic                  sram_enb;
   logic [AW-1:0]         sram_addrb;
   logic [DW-1:0]         sram_doutb;

   modport slave (
      input  w_req, w_addr, w_data, r_req, r_addr, sram_doutb,
      output w_gnt, r_gnt, r_valid, r_data,
      output sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
   );

   modport master (
      output w_req, w_addr, w_data, r_req, r_addr, sram_doutb,
      input  w_gnt, r_gnt, r_valid, r_data,
      input  sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Independent round-robin, burst-bounded arbiters for the SRAM write (A) and read (B) ports.
// Optional macro SRAM_ARB_FWD_EN forwards same-cycle, same-address write data to the read.
module sram_port_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int AW        = 12,
   parameter int DW        = 128,
   parameter int MAX_BURST = 4
) (
   input logic clk,
   input logic rst,
   sram_port_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, OWN} own_e;

   typedef struct packed {
      own_e          st;
      logic [IW-1:0] owner;
      logic [IW-1:0] rr;
      logic [3:0]    cnt;
   } arb_t;

   arb_t w_arb_q, w_arb_d;
   arb_t r_arb_q, r_arb_d;
   logic [NUM_REQ-1:0] w_gnt_raw, r_gnt_raw;
   logic [NUM_REQ-1:0] w_gnt, r_gnt;
   logic [NUM_REQ-1:0] r_valid_q, r_valid_d;
   logic               sram_ena, sram_enb;
   logic [AW-1:0]      sram_addra, sram_addrb;
   logic [DW-1:0]      sram_dina;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
      return (int'(v) == NUM_REQ - 1) ? '0 : v + IW'(1);
   endfunction

   // Owner keeps the port while it requests and has burst budget; otherwise the search
   // restarts just past the old owner, which may land back on it if it is alone.
   function automatic void arb_step(input arb_t cur, input logic [NUM_REQ-1:0] req,
                                    output arb_t nxt, output logic [NUM_REQ-1:0] gnt);
      logic [IW-1:0] start;
      logic [IW-1:0] idx;
      logic          found;
      nxt   = cur;
      gnt   = '0;
      start = cur.rr;
      idx   = '0;
      found = 1'b0;
      if (cur.st == OWN && req[cur.owner] && cur.cnt < 4'(MAX_BURST)) begin
         gnt[cur.owner] = 1'b1;
         nxt.cnt        = cur.cnt + 4'd1;
      end else begin
         if (cur.st == OWN) begin
            start  = wrap_inc(cur.owner);
            nxt.rr = start;
         end
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[(int'(start) + j) % NUM_REQ]) begin
               found = 1'b1;
               idx   = IW'((int'(start) + j) % NUM_REQ);
            end
         end
         if (found) begin
            gnt[idx]  = 1'b1;
            nxt.st    = OWN;
            nxt.owner = idx;
            nxt.cnt   = 4'd1;
         end else begin
            nxt.st  = IDLE;
            nxt.cnt = '0;
         end
      end
   endfunction

   always_comb begin
      w_arb_d   = w_arb_q;
      r_arb_d   = r_arb_q;
      w_gnt_raw = '0;
      r_gnt_raw = '0;
      arb_step(w_arb_q, bus.w_req, w_arb_d, w_gnt_raw);
      arb_step(r_arb_q, bus.r_req, r_arb_d, r_gnt_raw);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_arb_q <= '{st: IDLE, owner: '0, rr: '0, cnt: '0};
         r_arb_q <= '{st: IDLE, owner: '0, rr: '0, cnt: '0};
      end else begin
         w_arb_q <= w_arb_d;
         r_arb_q <= r_arb_d;
      end
   end

   // Grants are held low for the whole reset, not just until the next edge.
   always_comb begin
      w_gnt      = rst ? '0 : w_gnt_raw;
      r_gnt      = rst ? '0 : r_gnt_raw;
      sram_ena   = |w_gnt;
      sram_enb   = |r_gnt;
      sram_addra = '0;
      sram_dina  = '0;
      sram_addrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            sram_addra = bus.w_addr[i*AW +: AW];
            sram_dina  = bus.w_data[i*DW +: DW];
         end
         if (r_gnt[i]) begin
            sram_addrb = bus.r_addr[i*AW +: AW];
         end
      end
      r_valid_d = r_gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_q <= '0;
      end else begin
         r_valid_q <= r_valid_d;
      end
   end

`ifdef SRAM_ARB_FWD_EN
   logic          fwd_hit_q, fwd_hit_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;

   always_comb begin
      fwd_hit_d  = sram_ena && sram_enb && (sram_addra == sram_addrb);
      fwd_data_d = sram_dina;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   assign bus.r_data = fwd_hit_q ? fwd_data_q : bus.sram_doutb;
`else
   assign bus.r_data = bus.sram_doutb;
`endif

   assign bus.w_gnt      = w_gnt;
   assign bus.r_gnt      = r_gnt;
   assign bus.r_valid    = r_valid_q;
   assign bus.sram_ena   = sram_ena;
   assign bus.sram_wea   = sram_ena;
   assign bus.sram_addra = sram_addra;
   assign bus.sram_dina  = sram_dina;
   assign bus.sram_enb   = sram_enb;
   assign bus.sram_addrb = sram_addrb;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one MAX_BURST=4 instance on a behavioural
// read-before-write SRAM, plus a MAX_BURST=1 instance for plain round-robin rotation.
module tb_sram_port_arbiter;
   localparam int NUM_REQ = 4;
   localparam int AW      = 12;
   localparam int DW      = 128;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   sram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();
   sram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus_b1 ();

   sram_port_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   sram_port_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .MAX_BURST(1)) dut_b1 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b1.slave)
   );

   // Behavioural dual-port SRAM: synchronous read, old data on same-address collision.
   logic [DW-1:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.sram_enb) bus.sram_doutb <= mem[bus.sram_addrb];
      if (bus.sram_ena && bus.sram_wea) mem[bus.sram_addra] <= bus.sram_dina;
   end
   assign bus_b1.sram_doutb = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] w_req;
      logic [3:0] b_r_req;
      logic [3:0] exp_w_gnt;
      logic [3:0] exp_b_r_gnt;
      logic [3:0] exp_b_r_valid;
   } vec_t;

   vec_t vecs [12];

   task automatic applyStimulus(input logic [3:0] w_req, input logic [3:0] r_req,
                                input logic [3:0] b_r_req);
      bus.w_req     = w_req;
      bus.r_req     = r_req;
      bus_b1.w_req  = 4'b0000;
      bus_b1.r_req  = b_r_req;
   endtask

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   logic [DW-1:0] pat_a5, pat_11, pat_22, exp_coll;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pat_a5   = {16{8'hA5}};
      pat_11   = {16{8'h11}};
      pat_22   = {16{8'h22}};
`ifdef SRAM_ARB_FWD_EN
      exp_coll = pat_22;
`else
      exp_coll = pat_11;
`endif

      vecs[0]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0001, 4'b0000};
      vecs[1]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0010, 4'b0001};
      vecs[2]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0100, 4'b0010};
      vecs[3]  = '{4'b0011, 4'b1111, 4'b0001, 4'b1000, 4'b0100};
      vecs[4]  = '{4'b0011, 4'b1111, 4'b0010, 4'b0001, 4'b1000};
      vecs[5]  = '{4'b0011, 4'b1111, 4'b0010, 4'b0010, 4'b0001};
      vecs[6]  = '{4'b0011, 4'b1111, 4'b0010, 4'b0100, 4'b0010};
      vecs[7]  = '{4'b0011, 4'b1111, 4'b0010, 4'b1000, 4'b0100};
      vecs[8]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0001, 4'b1000};
      vecs[9]  = '{4'b0011, 4'b1111, 4'b0001, 4'b0010, 4'b0001};
      vecs[10] = '{4'b0011, 4'b1111, 4'b0001, 4'b0100, 4'b0010};
      vecs[11] = '{4'b0011, 4'b1111, 4'b0001, 4'b1000, 4'b0100};

      bus.r_addr    = '0;
      bus_b1.w_addr = '0;
      bus_b1.w_data = '0;
      bus_b1.r_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.w_addr[i*AW +: AW] = AW'(12'h010 + i);
         bus.w_data[i*DW +: DW] = {4{32'hC0DE_0000 + 32'(i)}};
      end

      // Reset with every requester active: nothing may be granted.
      rst = 1'b1;
      applyStimulus(4'b1111, 4'b1111, 4'b1111);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_w_gnt", DW'(bus.w_gnt), '0);
      checkOutput("rst_r_gnt", DW'(bus.r_gnt), '0);
      checkOutput("rst_ena", DW'(bus.sram_ena), '0);
      checkOutput("rst_enb", DW'(bus.sram_enb), '0);
      checkOutput("rst_r_valid", DW'(bus.r_valid), '0);
      checkOutput("rst_b1_r_gnt", DW'(bus_b1.r_gnt), '0);

      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;

      // Burst ownership on the write port and single-grant rotation on the read port.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         applyStimulus(vecs[k].w_req, 4'b0000, vecs[k].b_r_req);
         #1;
         checkOutput($sformatf("vec%0d_w_gnt", k), DW'(bus.w_gnt), DW'(vecs[k].exp_w_gnt));
         checkOutput($sformatf("vec%0d_b1_r_gnt", k), DW'(bus_b1.r_gnt), DW'(vecs[k].exp_b_r_gnt));
         checkOutput($sformatf("vec%0d_b1_r_valid", k), DW'(bus_b1.r_valid),
                     DW'(vecs[k].exp_b_r_valid));
      end

      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #1;
      checkOutput("idle_w_gnt", DW'(bus.w_gnt), '0);
      checkOutput("idle_ena", DW'(bus.sram_ena), '0);

      // Write through requester 2, read back through requester 1.
      @(negedge clk);
      bus.w_addr[2*AW +: AW] = 12'h123;
      bus.w_data[2*DW +: DW] = pat_a5;
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      #1;
      checkOutput("wr_w_gnt", DW'(bus.w_gnt), DW'(4'b0100));
      checkOutput("wr_ena", DW'(bus.sram_ena), DW'(1'b1));
      checkOutput("wr_wea", DW'(bus.sram_wea), DW'(1'b1));
      checkOutput("wr_addra", DW'(bus.sram_addra), DW'(12'h123));
      checkOutput("wr_dina", bus.sram_dina, pat_a5);

      @(negedge clk);
      bus.r_addr[1*AW +: AW] = 12'h123;
      applyStimulus(4'b0000, 4'b0010, 4'b0000);
      #1;
      checkOutput("rd_r_gnt", DW'(bus.r_gnt), DW'(4'b0010));
      checkOutput("rd_enb", DW'(bus.sram_enb), DW'(1'b1));
      checkOutput("rd_addrb", DW'(bus.sram_addrb), DW'(12'h123));
      checkOutput("rd_r_valid_early", DW'(bus.r_valid), '0);

      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #1;
      checkOutput("rd_r_valid", DW'(bus.r_valid), DW'(4'b0010));
      checkOutput("rd_r_data", bus.r_data, pat_a5);

      // Same-address write and read in one cycle.
      @(negedge clk);
      bus.w_addr[0*AW +: AW] = 12'h7FF;
      bus.w_data[0*DW +: DW] = pat_11;
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      #1;
      checkOutput("pre_w_gnt", DW'(bus.w_gnt), DW'(4'b0001));

      @(negedge clk);
      bus.w_data[0*DW +: DW] = pat_22;
      bus.r_addr[3*AW +: AW] = 12'h7FF;
      applyStimulus(4'b0001, 4'b1000, 4'b0000);
      #1;
      checkOutput("coll_w_gnt", DW'(bus.w_gnt), DW'(4'b0001));
      checkOutput("coll_r_gnt", DW'(bus.r_gnt), DW'(4'b1000));

      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #1;
      checkOutput("coll_r_valid", DW'(bus.r_valid), DW'(4'b1000));
      checkOutput("coll_r_data", bus.r_data, exp_coll);

      @(negedge clk);
      applyStimulus(4'b0000, 4'b1000, 4'b0000);
      #1;
      checkOutput("reread_r_gnt", DW'(bus.r_gnt), DW'(4'b1000));

      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #1;
      checkOutput("reread_r_valid", DW'(bus.r_valid), DW'(4'b1000));
      checkOutput("reread_r_data", bus.r_data, pat_22);

      // Reset while requester 3 owns the read port at burst count 2.
      @(negedge clk);
      applyStimulus(4'b0000, 4'b1000, 4'b0000);
      #1;
      checkOutput("own3_gnt1", DW'(bus.r_gnt), DW'(4'b1000));
      @(negedge clk);
      #1;
      checkOutput("own3_gnt2", DW'(bus.r_gnt), DW'(4'b1000));
      @(negedge clk);
      checkOutput("own3_r_valid", DW'(bus.r_valid), DW'(4'b1000));
      rst = 1'b1;
      #1;
      checkOutput("midrst_r_valid", DW'(bus.r_valid), '0);
      checkOutput("midrst_r_gnt", DW'(bus.r_gnt), '0);
      checkOutput("midrst_enb", DW'(bus.sram_enb), '0);
      @(negedge clk);
      checkOutput("midrst_r_valid_held", DW'(bus.r_valid), '0);
      applyStimulus(4'b0000, 4'b1111, 4'b0000);
      rst = 1'b0;
      #1;
      checkOutput("postrst_r_gnt", DW'(bus.r_gnt), DW'(4'b0001));
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      #1;
      checkOutput("postrst_r_valid", DW'(bus.r_valid), DW'(4'b0001));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
